// File: rtl/clk_div_monitor.sv
// clk_div_monitor
//   Self-check / frequency-lock monitor for a divided clock. The divided clock
//   (mon_in) is treated as data, synchronised into the clk_in domain, and each
//   of its high and low phases is measured in clk_in cycles.
//
// Ports
//   clk_in      reference clock, all logic on its rising edge
//   rstn        asynchronous active-low reset
//   mon_in      monitored divided clock (sampled as data)
//   clr         synchronous clear of err, period_cnt and lock progress
//   high_len    last measured high-phase length  [CNT_W]
//   low_len     last measured low-phase length   [CNT_W]
//   meas_valid  one-cycle pulse when high_len/low_len update
//   period_cnt  completed periods since reset/clr (wraps)  [16]
//   locked      LOCK_CNT consecutive periods of EXP_HALF/EXP_HALF
//   err         sticky: some completed period did not match
//   stuck       no mon_in edge for TIMEOUT cycles
module clk_div_monitor #(
  parameter int CNT_W       = 8,
  parameter int EXP_HALF    = 4,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rstn,
  input  logic             mon_in,
  input  logic             clr,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic             meas_valid,
  output logic [15:0]      period_cnt,
  output logic             locked,
  output logic             err,
  output logic             stuck
);

  typedef enum logic [1:0] {WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] EXP_LEN    = CNT_W'(EXP_HALF);
  localparam logic [CNT_W-1:0] STALL_TOP  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]       GOOD_TOP   = 4'(LOCK_CNT);
  localparam logic [2:0]       PRIME_TOP  = 3'(SYNC_STAGES + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // ---------------------------------------------------------------- synchroniser
  logic mon_s;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign mon_s = mon_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // NOTE: registers take non-blocking assignments so every flop samples the
      // pre-edge value of its neighbour; blocking here would collapse the chain.
      always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= mon_in;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign mon_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // ---------------------------------------------------------------- edge detect
  // Edges stay masked until the synchroniser has flushed its reset zeros, so a
  // mon_in that is already high at reset release is not mistaken for a rise.
  logic       mon_d;
  logic [2:0] prime_cnt;
  logic       primed;
  logic       rise;
  logic       fall;

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      mon_d     <= 1'b0;
      prime_cnt <= '0;
    end else begin
      mon_d <= mon_s;
      if (prime_cnt != PRIME_TOP) prime_cnt <= prime_cnt + 3'd1;
    end
  end

  assign primed = (prime_cnt == PRIME_TOP);
  assign rise   = primed &  mon_s & ~mon_d;
  assign fall   = primed & ~mon_s &  mon_d;

  // ---------------------------------------------------------------- FSM
  state_t           state;
  state_t           state_nxt;
  logic             period_done;
  logic             timeout_hit;
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) state <= WAIT_RISE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    period_done = 1'b0;
    timeout_hit = 1'b0;
    if (clr) begin
      state_nxt = WAIT_RISE;
    end else if (!(rise || fall) && stall_cnt == STALL_LAST) begin
      // An edge in the same cycle keeps this branch from firing: edge wins.
      timeout_hit = 1'b1;
      state_nxt   = WAIT_RISE;
    end else begin
      unique case (state)
        WAIT_RISE: if (rise) state_nxt = MEAS_HIGH;
        MEAS_HIGH: if (fall) state_nxt = MEAS_LOW;
        MEAS_LOW: begin
          if (rise) begin
            state_nxt   = MEAS_HIGH;
            period_done = 1'b1;
          end
        end
        default: state_nxt = WAIT_RISE;
      endcase
    end
  end

  // ---------------------------------------------------------------- datapath
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] hcnt_lat;
  logic [CNT_W-1:0] lcnt;
  logic [3:0]       good_cnt;
  logic [3:0]       good_inc;
  logic             period_good;

  assign good_inc    = (good_cnt == GOOD_TOP) ? good_cnt : good_cnt + 4'd1;
  assign period_good = (hcnt_lat == EXP_LEN) && (lcnt == EXP_LEN);

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      hcnt       <= '0;
      hcnt_lat   <= '0;
      lcnt       <= '0;
      stall_cnt  <= '0;
      good_cnt   <= '0;
      high_len   <= '0;
      low_len    <= '0;
      meas_valid <= 1'b0;
      period_cnt <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (clr) begin
        err        <= 1'b0;
        period_cnt <= '0;
        good_cnt   <= '0;
        locked     <= 1'b0;
        stall_cnt  <= '0;
        stuck      <= 1'b0;
      end else begin
        if (rise || fall)             stall_cnt <= '0;
        else if (stall_cnt != STALL_TOP) stall_cnt <= stall_cnt + CNT_ONE;

        if (rise) stuck <= 1'b0;

        if (timeout_hit) begin
          stuck    <= 1'b1;
          locked   <= 1'b0;
          good_cnt <= '0;
        end

        unique case (state)
          WAIT_RISE: begin
            if (rise) hcnt <= CNT_ONE;
          end
          MEAS_HIGH: begin
            if (fall) begin
              hcnt_lat <= hcnt;
              lcnt     <= CNT_ONE;
            end else begin
              hcnt <= sat_inc(hcnt);
            end
          end
          MEAS_LOW: begin
            if (!rise) lcnt <= sat_inc(lcnt);
          end
          default: ;
        endcase

        if (period_done) begin
          high_len   <= hcnt_lat;
          low_len    <= lcnt;
          meas_valid <= 1'b1;
          period_cnt <= period_cnt + 16'd1;
          hcnt       <= CNT_ONE;
          if (period_good) begin
            good_cnt <= good_inc;
            locked   <= (good_inc == GOOD_TOP);
          end else begin
            good_cnt <= '0;
            locked   <= 1'b0;
            err      <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Testbench for clk_div_monitor. The divided clock is described as a list of
// (high, low) phase lengths; a period is reported by the monitor when the next
// rise arrives, which is exactly when the reference model queues it.
module tb_clk_div_monitor;

  localparam int CNT_W       = 8;
  localparam int EXP_HALF    = 4;
  localparam int LOCK_CNT    = 4;
  localparam int TIMEOUT     = 64;
  localparam int SYNC_STAGES = 2;

  logic             clk_in = 1'b0;
  logic             rstn   = 1'b0;
  logic             mon_in = 1'b0;
  logic             clr    = 1'b0;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic             meas_valid;
  logic [15:0]      period_cnt;
  logic             locked;
  logic             err;
  logic             stuck;

  clk_div_monitor #(
    .CNT_W      (CNT_W),
    .EXP_HALF   (EXP_HALF),
    .LOCK_CNT   (LOCK_CNT),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk_in    (clk_in),
    .rstn      (rstn),
    .mon_in    (mon_in),
    .clr       (clr),
    .high_len  (high_len),
    .low_len   (low_len),
    .meas_valid(meas_valid),
    .period_cnt(period_cnt),
    .locked    (locked),
    .err       (err),
    .stuck     (stuck)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  typedef struct {
    int h;
    int l;
    bit lk;
    bit er;
    int pc;
  } report_t;

  report_t exp_q[$];

  bit m_open;   // a complete (high, low) period waits for the next rise
  int m_h;
  int m_l;
  int m_good;   // consecutive good periods, capped at LOCK_CNT
  bit m_locked;
  bit m_err;
  int m_pc;
  int last_h;
  int last_l;

  function automatic void model_rise();
    report_t r;
    if (m_open) begin
      m_pc = (m_pc + 1) % 65536;
      if (m_h == EXP_HALF && m_l == EXP_HALF) begin
        m_good   = (m_good < LOCK_CNT) ? m_good + 1 : LOCK_CNT;
        m_locked = (m_good == LOCK_CNT);
      end else begin
        m_good   = 0;
        m_locked = 1'b0;
        m_err    = 1'b1;
      end
      r.h  = m_h;
      r.l  = m_l;
      r.lk = m_locked;
      r.er = m_err;
      r.pc = m_pc;
      exp_q.push_back(r);
      last_h = m_h;
      last_l = m_l;
    end
    m_open = 1'b0;
  endfunction

  function automatic void model_reset();
    m_open   = 1'b0;
    m_good   = 0;
    m_locked = 1'b0;
    m_err    = 1'b0;
    m_pc     = 0;
    last_h   = 0;
    last_l   = 0;
  endfunction

  function automatic void model_clr();
    m_open   = 1'b0;
    m_good   = 0;
    m_locked = 1'b0;
    m_err    = 1'b0;
    m_pc     = 0;
  endfunction

  function automatic void model_timeout();
    m_open   = 1'b0;
    m_good   = 0;
    m_locked = 1'b0;
  endfunction

  // ---------------------------------------------------------------- stimulus helpers
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic drive_period(input int h, input int l);
    model_rise();
    mon_in = 1'b1;
    wait_neg(h);
    mon_in = 1'b0;
    wait_neg(l);
    m_open = 1'b1;
    m_h    = h;
    m_l    = l;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_high_len"},   high_len,   0);
    check({tag, "_low_len"},    low_len,    0);
    check({tag, "_meas_valid"}, meas_valid, 0);
    check({tag, "_period_cnt"}, period_cnt, 0);
    check({tag, "_locked"},     locked,     0);
    check({tag, "_err"},        err,        0);
    check({tag, "_stuck"},      stuck,      0);
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin
    report_t e;
    forever begin
      @(negedge clk_in);
      if (rstn && meas_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_meas_valid", meas_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("rep_high_len",   high_len,   e.h);
          check("rep_low_len",    low_len,    e.l);
          check("rep_locked",     locked,     e.lk);
          check("rep_err",        err,        e.er);
          check("rep_period_cnt", period_cnt, e.pc);
          check("rep_stuck",      stuck,      0);
        end
      end
    end
  end

  // ---------------------------------------------------------------- test sequence
  initial begin
    model_reset();

    // Reset state, release at 10 ns with a clean 4/4 stream.
    #8;
    check_all_zero("reset");
    #2 rstn = 1'b1;
    wait_neg(6);
    repeat (11) drive_period(4, 4);
    check("stream_period_cnt", period_cnt, 10);
    check("stream_locked",     locked,     1);
    check("stream_err",        err,        0);

    // One 5/3 period breaks lock; four good ones restore it, err stays.
    drive_period(5, 3);
    repeat (5) drive_period(4, 4);

    // mon_in held high 80 cycles: stuck appears 64 cycles after the edge.
    model_rise();
    mon_in = 1'b1;
    wait_neg(66);
    check("stall_pre_stuck",  stuck,  0);
    check("stall_pre_locked", locked, 1);
    wait_neg(1);
    check("stall_stuck",  stuck,  1);
    check("stall_locked", locked, 0);
    check("stall_err",    err,    1);
    model_timeout();
    wait_neg(13);
    mon_in = 1'b0;
    wait_neg(4);
    model_rise();
    mon_in = 1'b1;
    wait_neg(2);
    check("resume_stuck_held", stuck, 1);
    wait_neg(1);
    check("resume_stuck_clear", stuck, 0);
    wait_neg(1);
    mon_in = 1'b0;
    wait_neg(4);
    m_open = 1'b1;
    m_h    = 4;
    m_l    = 4;

    // Randomised stream, mostly nominal periods.
    for (int i = 0; i < 40; i++) begin
      int h;
      int l;
      if ($urandom_range(0, 3) != 0) begin
        h = EXP_HALF;
        l = EXP_HALF;
      end else begin
        h = $urandom_range(1, 7);
        l = $urandom_range(1, 7);
      end
      drive_period(h, l);
    end

    // Reset in the middle of a low phase: outputs clear without a clock.
    model_rise();
    mon_in = 1'b1;
    wait_neg(4);
    mon_in = 1'b0;
    wait_neg(3);
    #2 rstn = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();

    // mon_in high through reset and release must not count as a rise.
    mon_in = 1'b1;
    wait_neg(3);
    rstn = 1'b1;
    wait_neg(10);
    mon_in = 1'b0;
    wait_neg(4);
    check("prime_period_cnt", period_cnt, 0);
    check("prime_meas_valid", meas_valid, 0);

    // Build err=1, period_cnt=7, locked=1, then clear.
    drive_period(4, 4);
    drive_period(4, 4);
    drive_period(5, 3);
    repeat (4) drive_period(4, 4);
    model_rise();
    mon_in = 1'b1;
    wait_neg(4);
    mon_in = 1'b0;
    wait_neg(3);
    check("pre_clr_err",        err,        m_err);
    check("pre_clr_period_cnt", period_cnt, 7);
    check("pre_clr_locked",     locked,     1);
    clr = 1'b1;
    wait_neg(1);
    clr = 1'b0;
    model_clr();
    check("clr_err",        err,        0);
    check("clr_period_cnt", period_cnt, 0);
    check("clr_locked",     locked,     0);
    check("clr_high_len",   high_len,   last_h);
    check("clr_low_len",    low_len,    last_l);
    wait_neg(3);
    repeat (6) drive_period(4, 4);
    wait_neg(10);

    check("all_reports_seen", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
